// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_init_state_e;

endpackage

// File: rtl/apb_initiator_if.sv
// APB4 bus bundle: master modport for the requester, slave modport for a peripheral.
interface apb_initiator_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = 12
);

    logic                  psel;
    logic                  penable;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pwstrb;
    logic                  pready;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_initiator.sv
// Single-beat valid/ready request -> APB4 SETUP/ACCESS, response returned on a valid/ready channel.
// Zero-wait latency: accept T, SETUP T+1, ACCESS T+2, rsp_valid T+3; one transfer in flight, stalls on rsp_ready.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    apb_initiator_if.master       apb
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_init_state_e       state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0] pwstrb_q, pwstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_hit;

    // TIMEOUT==0 disables the abort path entirely.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pwstrb_d      = pwstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pwstrb_d = req_write ? req_wstrb : '0;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready in the final allowed cycle still completes normally.
                if (apb.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : apb.prdata;
                    rsp_err_d     = apb.pslverr;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pwstrb_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pwstrb_q      <= pwstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwstrb  = pwstrb_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: scripted APB slave plus a response scoreboard.
module tb_apb_initiator;
    import apb_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_write = 1'b0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rsp   = 0;
    int          psel_cyc = 0;
    int          pen_cyc  = 0;
    int          bad_strb = 0;
    exp_t        exp_q[$];

    // scripted slave
    int          wait_n = 0;
    logic [31:0] s_rdata = 32'h1234_5678;
    logic        s_err = 1'b0;
    int          acc_cnt = 0;

    apb_initiator_if #(.ADDR_W(ADDR_W)) apb_bus ();

    apb_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .apb(apb_bus.master)
    );

    always #5 clk = ~clk;

    assign apb_bus.pready  = apb_bus.psel && apb_bus.penable && (acc_cnt >= wait_n);
    assign apb_bus.prdata  = s_rdata;
    assign apb_bus.pslverr = s_err;

    always @(posedge clk) begin
        if (apb_bus.psel && apb_bus.penable && !apb_bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin
        exp_t e;
        if (req_valid && req_ready && !rst) begin
            psel_cyc = 0;
            pen_cyc  = 0;
            bad_strb = 0;
        end else begin
            if (apb_bus.psel) psel_cyc++;
            if (apb_bus.penable) pen_cyc++;
            if (apb_bus.psel && !apb_bus.pwrite && apb_bus.pwstrb != 4'h0) bad_strb++;
        end
        if (rsp_valid && rsp_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_timeout", rsp_timeout, e.to);
            end
            n_rsp++;
        end
    end

    // Present a request; returns at the negedge of the accepting cycle.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accepted", req_ready, 1);
    endtask

    task automatic drop_req();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", (n_rsp >= target), 1);
        @(negedge clk);
    endtask

    initial begin
        int viol;
        int n;
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", apb_bus.psel, 0);
        chk("rst_penable", apb_bus.penable, 0);
        chk("rst_pwrite", apb_bus.pwrite, 0);
        chk("rst_paddr", apb_bus.paddr, 0);
        chk("rst_pwdata", apb_bus.pwdata, 0);
        chk("rst_pwstrb", apb_bus.pwstrb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: zero-wait write
        wait_n = 0; s_err = 0; s_rdata = 32'hCAFE_F00D;
        issue(1'b1, 12'h004, 32'h41, 4'b0001);
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        drop_req();
        @(negedge clk);
        chk("t1_setup_psel", apb_bus.psel, 1);
        chk("t1_setup_penable", apb_bus.penable, 0);
        chk("t1_paddr", apb_bus.paddr, 12'h004);
        chk("t1_pwdata", apb_bus.pwdata, 32'h41);
        chk("t1_pwstrb", apb_bus.pwstrb, 4'b0001);
        chk("t1_pwrite", apb_bus.pwrite, 1);
        chk("t1_req_ready_busy", req_ready, 0);
        @(negedge clk);
        chk("t1_access_psel", apb_bus.psel, 1);
        chk("t1_access_penable", apb_bus.penable, 1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_psel_off", apb_bus.psel, 0);
        chk("t1_penable_off", apb_bus.penable, 0);
        @(negedge clk);
        chk("t1_rsp_valid_clr", rsp_valid, 0);
        chk("t1_req_ready_idle", req_ready, 1);
        chk("t1_paddr_hold", apb_bus.paddr, 12'h004);

        // 2: read with two wait states
        wait_n = 2; s_rdata = 32'h60;
        issue(1'b0, 12'h008, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back('{rdata: 32'h60, err: 1'b0, to: 1'b0});
        drop_req();
        wait_rsp(2);
        chk("t2_psel_cycles", psel_cyc, 4);
        chk("t2_penable_cycles", pen_cyc, 3);
        chk("t2_read_strb_zero", bad_strb, 0);

        // 3: write with slave error; read data must not leak
        wait_n = 0; s_err = 1; s_rdata = 32'hDEAD_BEEF;
        issue(1'b1, 12'h00C, 32'h1, 4'hF);
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        drop_req();
        wait_rsp(3);
        s_err = 0;

        // 4a: never ready -> abort after TIMEOUT access cycles
        wait_n = 1000;
        issue(1'b0, 12'h010, 32'h0, 4'h0);
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        drop_req();
        wait_rsp(4);
        chk("t4_timeout_penable", pen_cyc, TIMEOUT);
        chk("t4_timeout_psel", psel_cyc, TIMEOUT + 1);

        // 4b: ready in the last allowed access cycle completes normally
        wait_n = TIMEOUT - 1; s_rdata = 32'h77;
        issue(1'b0, 12'h014, 32'h0, 4'h0);
        exp_q.push_back('{rdata: 32'h77, err: 1'b0, to: 1'b0});
        drop_req();
        wait_rsp(5);
        chk("t4b_penable", pen_cyc, TIMEOUT);

        // 5: response stall with a second request held
        wait_n = 0; s_rdata = 32'h55AA;
        rsp_ready = 1'b0;
        issue(1'b0, 12'h020, 32'h0, 4'h0);
        exp_q.push_back('{rdata: 32'h55AA, err: 1'b0, to: 1'b0});
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 12'h024; req_wdata = 32'h99; req_wstrb = 4'h3;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_rdata !== 32'h55AA || rsp_err || req_ready || apb_bus.psel)
                viol++;
            @(negedge clk);
        end
        chk("t5_stall_stable", viol, 0);
        chk("t5_stall_rsp_count", n_rsp, 5);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_req_ready_after_hs", req_ready, 1);
        chk("t5_no_psel_yet", apb_bus.psel, 0);
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        drop_req();
        @(negedge clk);
        chk("t5_second_setup", apb_bus.psel, 1);
        chk("t5_second_paddr", apb_bus.paddr, 12'h024);
        wait_rsp(7);

        // 6: reset during ACCESS discards the transfer
        wait_n = 1000;
        base = n_rsp;
        issue(1'b1, 12'h030, 32'h5, 4'hF);
        drop_req();
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_access", apb_bus.penable, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_psel_rst", apb_bus.psel, 0);
        chk("t6_penable_rst", apb_bus.penable, 0);
        chk("t6_rsp_valid_rst", rsp_valid, 0);
        chk("t6_req_ready_rst", req_ready, 1);
        repeat (10) @(negedge clk);
        chk("t6_no_response", n_rsp, base);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
